// File: rtl/reg_access_pkg.sv
// Shared encodings and helpers for the register-access stage.
// Holds the writeback lane encodings, the lane-merge function and the
// pending-counter ceiling derivation.
package reg_access_pkg;

    // Writeback size encodings (data is right-aligned on the bus)
    localparam logic [1:0] WB_SIZE_BYTE_LO = 2'd0;
    localparam logic [1:0] WB_SIZE_BYTE_HI = 2'd1;
    localparam logic [1:0] WB_SIZE_WORD    = 2'd2;
    localparam logic [1:0] WB_SIZE_DWORD   = 2'd3;

    // Largest count a CNT_W-bit pending counter can hold
    function automatic int unsigned cnt_max(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

    // Merge right-aligned writeback data into the low 32 bits of a register.
    // Byte-hi data arrives in [7:0] and lands in [15:8]; untouched bits keep old_val.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_val,
        input logic [31:0] data,
        input logic [1:0]  size
    );
        logic [31:0] res;
        res = old_val;
        case (size)
            WB_SIZE_BYTE_LO: res[7:0]  = data[7:0];
            WB_SIZE_BYTE_HI: res[15:8] = data[7:0];
            WB_SIZE_WORD:    res[15:0] = data[15:0];
            WB_SIZE_DWORD:   res       = data;
            default:         res       = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters.
// Each cycle a register's count drops by the number of writeback ports hitting
// it (clamped at zero, so untracked writes are harmless) and rises by one when
// an accepted instruction names it as destination. Flush clears everything.
module reg_scoreboard
    import reg_access_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int NUM_WB   = 2,
    parameter int CNT_W    = 2,
    localparam int RA_W    = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic [NUM_WB-1:0]      i_wb_en,
    input  logic [NUM_WB*RA_W-1:0] i_wb_reg,
    input  logic                   i_inc_en,
    input  logic [RA_W-1:0]        i_inc_reg,
    output logic [NUM_REGS-1:0]    o_busy,
    output logic [NUM_REGS-1:0]    o_full,
    output logic [NUM_REGS-1:0]    o_sb_pending
);

    localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic [CNT_W-1:0]    w_cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0] w_pend_next;
    logic [NUM_REGS-1:0] r_pending;

    // Next-count, hazard (count after this cycle's writebacks) and full flags
    always_comb begin
        int unsigned v_cnt;
        int unsigned v_dec;
        int unsigned v_rem;
        int unsigned v_inc;
        o_busy      = {NUM_REGS{1'b0}};
        o_full      = {NUM_REGS{1'b0}};
        w_pend_next = {NUM_REGS{1'b0}};
        v_cnt       = 32'd0;
        v_dec       = 32'd0;
        v_rem       = 32'd0;
        v_inc       = 32'd0;
        for (int r = 0; r < NUM_REGS; r++) begin
            v_dec = 32'd0;
            for (int p = 0; p < NUM_WB; p++) begin
                v_dec = v_dec + ((i_wb_en[p] && (i_wb_reg[p*RA_W +: RA_W] == RA_W'(r))) ? 32'd1 : 32'd0);
            end
            v_cnt = 32'(r_cnt[r]);
            v_rem = (v_cnt > v_dec) ? (v_cnt - v_dec) : 32'd0;
            v_inc = (i_inc_en && (i_inc_reg == RA_W'(r))) ? 32'd1 : 32'd0;
            o_busy[r]      = (v_rem != 32'd0);
            o_full[r]      = (r_cnt[r] == CNT_MAX_V);
            w_cnt_next[r]  = i_flush ? {CNT_W{1'b0}} : CNT_W'(v_rem + v_inc);
            w_pend_next[r] = (w_cnt_next[r] != {CNT_W{1'b0}});
        end
    end

    // Counter array and registered pending vector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= {CNT_W{1'b0}};
            end
            r_pending <= {NUM_REGS{1'b0}};
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= w_cnt_next[r];
            end
            r_pending <= w_pend_next;
        end
    end

    assign o_sb_pending = r_pending;

endmodule

// File: rtl/register_access_scoreboard.sv
// Register-access stage: decode -> RF read -> output skid register.
// Sources read the RF merged with this cycle's writebacks, so a producer's
// writeback wakes its consumer in the same cycle. RAW hazards and counter
// saturation are tracked by reg_scoreboard.
module register_access_scoreboard
    import reg_access_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 8,
    parameter int NUM_RD    = 2,
    parameter int NUM_WB    = 2,
    parameter int CNT_W     = 2,
    parameter int PAYLOAD_W = 64,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     d_valid,
    output logic                     d_ready,
    input  logic [NUM_RD*RA_W-1:0]   d_src_reg,
    input  logic [NUM_RD-1:0]        d_src_en,
    input  logic [RA_W-1:0]          d_dst_reg,
    input  logic                     d_dst_en,
    input  logic [PAYLOAD_W-1:0]     d_payload,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [NUM_RD*DATA_W-1:0] r_src_data,
    output logic [RA_W-1:0]          r_dst_reg,
    output logic                     r_dst_en,
    output logic [PAYLOAD_W-1:0]     r_payload,
    input  logic [NUM_WB-1:0]        wb_en,
    input  logic [NUM_WB*RA_W-1:0]   wb_reg,
    input  logic [NUM_WB*2-1:0]      wb_size,
    input  logic [NUM_WB*DATA_W-1:0] wb_data,
    output logic [NUM_REGS-1:0]      sb_pending
);

    logic [DATA_W-1:0]        r_rf [NUM_REGS];
    logic [DATA_W-1:0]        w_rf_next [NUM_REGS];
    logic [NUM_RD*DATA_W-1:0] w_src_data;
    logic [NUM_REGS-1:0]      w_busy;
    logic [NUM_REGS-1:0]      w_full;
    logic                     w_hazard;
    logic                     w_ready;
    logic                     w_accept;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WB   (NUM_WB),
        .CNT_W    (CNT_W)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .i_flush      (flush),
        .i_wb_en      (wb_en),
        .i_wb_reg     (wb_reg),
        .i_inc_en     (w_accept & d_dst_en),
        .i_inc_reg    (d_dst_reg),
        .o_busy       (w_busy),
        .o_full       (w_full),
        .o_sb_pending (sb_pending)
    );

    // RF image after this cycle's writebacks; later ports override earlier ones
    always_comb begin
        logic [DATA_W-1:0] v_merged;
        v_merged = {DATA_W{1'b0}};
        for (int r = 0; r < NUM_REGS; r++) begin
            w_rf_next[r] = r_rf[r];
            for (int p = 0; p < NUM_WB; p++) begin
                v_merged        = w_rf_next[r];
                v_merged[31:0]  = merge_lanes(w_rf_next[r][31:0],
                                              wb_data[p*DATA_W +: 32],
                                              wb_size[p*2 +: 2]);
                w_rf_next[r]    = (wb_en[p] && (wb_reg[p*RA_W +: RA_W] == RA_W'(r)))
                                  ? v_merged : w_rf_next[r];
            end
        end
    end

    // Forwarded source reads and RAW hazard detection
    always_comb begin
        w_src_data = {NUM_RD*DATA_W{1'b0}};
        w_hazard   = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_src_data[i*DATA_W +: DATA_W] = w_rf_next[d_src_reg[i*RA_W +: RA_W]];
            w_hazard = w_hazard | (d_src_en[i] & w_busy[d_src_reg[i*RA_W +: RA_W]]);
        end
    end

    assign w_ready  = !flush && !w_hazard && !(d_dst_en && w_full[d_dst_reg]) &&
                      (!r_valid || r_ready);
    assign w_accept = d_valid & w_ready;
    assign d_ready  = w_ready;

    // Register file update (writebacks land even during flush)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_rf[r] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_rf[r] <= w_rf_next[r];
            end
        end
    end

    // Output skid register: load on accept, drain on ready, hold on stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_src_data <= {NUM_RD*DATA_W{1'b0}};
            r_dst_reg  <= {RA_W{1'b0}};
            r_dst_en   <= 1'b0;
            r_payload  <= {PAYLOAD_W{1'b0}};
        end else if (flush) begin
            r_valid    <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_src_data <= w_src_data;
            r_dst_reg  <= d_dst_reg;
            r_dst_en   <= d_dst_en;
            r_payload  <= d_payload;
        end else if (r_ready) begin
            r_valid    <= 1'b0;
        end else begin
            r_valid    <= r_valid;
        end
    end

endmodule
